// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the shift sequencer: shift type codes and the controller state.
package shift_pkg;

    localparam logic [1:0] SHIFT_SRL = 2'b00;
    localparam logic [1:0] SHIFT_SLL = 2'b01;
    localparam logic [1:0] SHIFT_SRA = 2'b10;
    localparam logic [1:0] SHIFT_RSV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response bundle between the two shift requesters, the result consumer and the sequencer.
interface shift_sequencer_if #(
    parameter int WIDTH = 32
) ();
    import shift_pkg::*;

    localparam int SAW = $clog2(WIDTH);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // Request payloads only matter on that edge; rsp_data/rsp_id hold steady while rsp_valid waits for rsp_ready.
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [SAW-1:0]   req0_shamt;
    logic [1:0]       req0_type;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [SAW-1:0]   req1_shamt;
    logic [1:0]       req1_type;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_id;

    logic             busy;
    state_t           dbg_state;

    modport master (
        output req0_valid, req0_a, req0_shamt, req0_type,
        output req1_valid, req1_a, req1_shamt, req1_type,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_data, rsp_id, busy, dbg_state
    );

    modport slave (
        input  req0_valid, req0_a, req0_shamt, req0_type,
        input  req1_valid, req1_a, req1_shamt, req1_type,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_data, rsp_id, busy, dbg_state
    );

endinterface

// File: rtl/shift_step_unit.sv
// Combinational single-step shifter; distance is bounded by the caller to at most STEP.
module shift_step_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DW    = 6
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [DW-1:0]    dist_i,
    input  logic [1:0]       type_i,
    output logic [WIDTH-1:0] y_o
);

    always_comb begin
        y_o = a_i;
        case (type_i)
            SHIFT_SRL: y_o = a_i >> dist_i;
            SHIFT_SLL: y_o = a_i << dist_i;
            SHIFT_SRA: y_o = $signed(a_i) >>> dist_i;
            default:   y_o = a_i;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Shift controller: round-robin arbiter over two requesters, multi-cycle stepped shift, registered response.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 8
) (
    input  logic               clk,
    input  logic               rst,
    shift_sequencer_if.slave   bus
);

    localparam int SAW = $clog2(WIDTH);
    localparam int RW  = SAW + 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic [1:0]       type_q, type_d;
    logic             id_q, id_d;
    logic             rr_q, rr_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_id_q, rsp_id_d;

    logic             any_valid;
    logic             grant;
    logic [WIDTH-1:0] sel_a;
    logic [SAW-1:0]   sel_shamt;
    logic [1:0]       sel_type;
    logic [RW-1:0]    step_d;
    logic [WIDTH-1:0] step_y;

    // rr_q names the requester preferred on a tie; it flips to the other one on every accept.
    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = rr_q;
        end else begin
            grant = bus.req1_valid;
        end
        sel_a     = grant ? bus.req1_a     : bus.req0_a;
        sel_shamt = grant ? bus.req1_shamt : bus.req0_shamt;
        sel_type  = grant ? bus.req1_type  : bus.req0_type;
    end

    assign bus.req0_ready = (state_q == IDLE) & bus.req0_valid & ~grant;
    assign bus.req1_ready = (state_q == IDLE) & bus.req1_valid & grant;

    assign step_d = (rem_q > RW'(STEP)) ? RW'(STEP) : rem_q;

    shift_step_unit #(
        .WIDTH (WIDTH),
        .DW    (RW)
    ) u_step (
        .a_i    (acc_q),
        .dist_i (step_d),
        .type_i (type_q),
        .y_o    (step_y)
    );

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        type_d     = type_q;
        id_d       = id_q;
        rr_d       = rr_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    acc_d  = sel_a;
                    rem_d  = {1'b0, sel_shamt};
                    type_d = sel_type;
                    id_d   = grant;
                    rr_d   = ~grant;
                    if (sel_shamt == '0 || sel_type == SHIFT_RSV) begin
                        state_d    = DONE;
                        rsp_data_d = sel_a;
                        rsp_id_d   = grant;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                acc_d = step_y;
                rem_d = rem_q - step_d;
                if (rem_q <= RW'(STEP)) begin
                    state_d    = DONE;
                    rsp_data_d = step_y;
                    rsp_id_d   = id_q;
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            rem_q      <= '0;
            type_q     <= SHIFT_SRL;
            id_q       <= 1'b0;
            rr_q       <= 1'b0;
            rsp_data_q <= '0;
            rsp_id_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            rem_q      <= rem_d;
            type_q     <= type_d;
            id_q       <= id_d;
            rr_q       <= rr_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    assign bus.rsp_valid = (state_q == DONE);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: arbitration, stepped shifts, response backpressure and mid-op reset.
module tb_shift_sequencer;
    import shift_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shift_sequencer_if #(.WIDTH(W)) bus ();

    shift_sequencer #(
        .WIDTH (W),
        .STEP  (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] exp_q[$];
    logic         exp_id_q[$];

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_shamt = '0; bus.req0_type = SHIFT_SRL;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_shamt = '0; bus.req1_type = SHIFT_SRL;
        bus.rsp_ready  = 1'b1;
    endtask

    task automatic drive_req(input bit id, input logic [W-1:0] a, input logic [4:0] sh, input logic [1:0] ty);
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_shamt = sh; bus.req1_type = ty;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_shamt = sh; bus.req0_type = ty;
        end
    endtask

    // Issues one op on a free sequencer and returns at the negedge where rsp_valid is first seen.
    task automatic issue(input bit id, input logic [W-1:0] a, input logic [4:0] sh, input logic [1:0] ty,
                         input int exp_lat, input logic [W-1:0] exp_data, input string tag);
        int lat;
        @(negedge clk);
        drive_req(id, a, sh, ty);
        exp_q.push_back(exp_data);
        exp_id_q.push_back(id);
        #1;
        check({tag, "_ready"}, W'(id ? bus.req1_ready : bus.req0_ready), W'(1));
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!bus.rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, W'(lat), W'(exp_lat));
    endtask

    task automatic retire(input string tag);
        logic [W-1:0] ed;
        logic         ei;
        ed = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        ei = (exp_id_q.size() > 0) ? exp_id_q.pop_front() : 1'bx;
        check({tag, "_data"}, bus.rsp_data, ed);
        check({tag, "_id"}, W'(bus.rsp_id), W'(ei));
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_valid_drop"}, W'(bus.rsp_valid), W'(0));
        check({tag, "_busy_drop"}, W'(bus.busy), W'(0));
        check({tag, "_data_kept"}, bus.rsp_data, ed);
    endtask

    bit exp_grant = 1'b0;
    int n_g0 = 0, n_g1 = 0, bad_ready = 0;

    task automatic mon_cycle();
        bit g;
        logic [W-1:0] ed;
        logic         ei;
        if (bus.busy && (bus.req0_ready || bus.req1_ready)) bad_ready++;
        if (bus.req0_ready || bus.req1_ready) begin
            g = bus.req1_ready;
            check("t3_grant", W'(g), W'(exp_grant));
            exp_grant = ~exp_grant;
            if (g) begin
                n_g1++;
                exp_q.push_back(32'hFFFF_FFFF);
            end else begin
                n_g0++;
                exp_q.push_back(32'h0000_000F);
            end
            exp_id_q.push_back(g);
        end
        if (bus.rsp_valid) begin
            ed = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            ei = (exp_id_q.size() > 0) ? exp_id_q.pop_front() : 1'bx;
            check("t3_rsp_data", bus.rsp_data, ed);
            check("t3_rsp_id", W'(bus.rsp_id), W'(ei));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        int seen;
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        check("rst_busy", W'(bus.busy), W'(0));
        check("rst_rsp_valid", W'(bus.rsp_valid), W'(0));
        check("rst_rsp_data", bus.rsp_data, W'(0));
        check("rst_rsp_id", W'(bus.rsp_id), W'(0));
        check("rst_state", W'(bus.dbg_state), W'(IDLE));
        rst = 1'b0;

        // Both requesters valid from reset: grants alternate starting with req0.
        @(negedge clk);
        drive_req(1'b0, 32'h0000_00F0, 5'd4, SHIFT_SRL);
        drive_req(1'b1, 32'h8000_0000, 5'd31, SHIFT_SRA);
        #1;
        i = 0;
        forever begin
            mon_cycle();
            i++;
            if ((i >= 60 && bus.busy) || i >= 80) break;
            @(negedge clk);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (15) begin
            @(negedge clk);
            mon_cycle();
        end
        check("t3_no_ready_when_busy", W'(bad_ready), W'(0));
        check("t3_req0_served", W'(n_g0 >= 3), W'(1));
        check("t3_req1_served", W'(n_g1 >= 3), W'(1));
        check("t3_drained", W'(exp_q.size()), W'(0));

        issue(1'b0, 32'h0000_00F0, 5'd4, SHIFT_SRL, 2, 32'h0000_000F, "t1");
        retire("t1");

        issue(1'b1, 32'h8000_0000, 5'd31, SHIFT_SRA, 5, 32'hFFFF_FFFF, "t2");
        retire("t2");

        issue(1'b0, 32'h1234_5678, 5'd0, SHIFT_SLL, 1, 32'h1234_5678, "t4_zero");
        retire("t4_zero");
        issue(1'b1, 32'h1234_5678, 5'd5, SHIFT_RSV, 1, 32'h1234_5678, "t4_rsv");
        retire("t4_rsv");

        // Response backpressure with the other requester waiting.
        bus.rsp_ready = 1'b0;
        issue(1'b0, 32'h0000_0001, 5'd9, SHIFT_SLL, 3, 32'h0000_0200, "t5");
        drive_req(1'b1, 32'hA5A5_A5A5, 5'd3, SHIFT_SRL);
        repeat (6) begin
            @(negedge clk);
            check("t5_hold_data", bus.rsp_data, 32'h0000_0200);
            check("t5_hold_valid", W'(bus.rsp_valid), W'(1));
            check("t5_hold_busy", W'(bus.busy), W'(1));
            check("t5_no_ready", W'(bus.req1_ready), W'(0));
        end
        bus.req1_valid = 1'b0;
        retire("t5");

        // Reset in the middle of a stepped shift.
        @(negedge clk);
        drive_req(1'b0, 32'hFFFF_0000, 5'd20, SHIFT_SRL);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        @(negedge clk);
        check("t6_running", W'(bus.dbg_state), W'(RUN));
        rst = 1'b1;
        #1;
        check("t6_rst_busy", W'(bus.busy), W'(0));
        check("t6_rst_valid", W'(bus.rsp_valid), W'(0));
        check("t6_rst_data", bus.rsp_data, W'(0));
        check("t6_rst_id", W'(bus.rsp_id), W'(0));
        @(negedge clk);
        check("t6_rst_hold_busy", W'(bus.busy), W'(0));
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        check("t6_no_response", W'(seen), W'(0));
        issue(1'b0, 32'hFFFF_0000, 5'd1, SHIFT_SRL, 2, 32'h7FFF_8000, "t6_after");
        retire("t6_after");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
